set_bit_scanner: RTL

//  Expands a WIDTH-bit vector back into the positions of its set bits, one index per beat,

---
 rtl/set_bit_scanner_pkg.sv | 19 +
 rtl/set_bit_scanner_if.sv | 51 +++++
 rtl/set_bit_scanner_lsb_priority_encoder.sv | 34 +++
 rtl/set_bit_scanner.sv | 122 ++++++++++++
 4 files changed

// File: rtl/set_bit_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_defs (package)
//  Description : Shared widths and FSM state encoding for the set-bit scanner
//                (set_bit_scanner, lsb_priority_encoder, set_bit_scanner_if).
//  Revision    : 1.0  initial release
// ============================================================================
package scan_defs;

  localparam int SCAN_WIDTH = 32;
  localparam int SCAN_IDXW  = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

endpackage : scan_defs
`default_nettype wire

// File: rtl/set_bit_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : set_bit_scanner_if
//  Description : Valid/ready bundle for the set-bit scanner.
//                Producer side : in_valid, in_data  -> scanner ; in_ready <-
//                Consumer side : out_valid, out_index, out_last, out_empty ->
//                                out_ready <-
//                master modport = environment (producer + consumer)
//                slave  modport = scanner
//  Revision    : 1.0  initial release
// ============================================================================
interface set_bit_scanner_if
  import scan_defs::*;
#(
  parameter int WIDTH = SCAN_WIDTH,
  parameter int IDXW  = SCAN_IDXW
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_index;
  logic             out_last;
  logic             out_empty;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_index,
    input  out_last,
    input  out_empty
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_index,
    output out_last,
    output out_empty
  );

endinterface : set_bit_scanner_if
`default_nettype wire

// File: rtl/set_bit_scanner_lsb_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_priority_encoder
//  Description : Purely combinational priority encoder, lowest set bit wins.
//                i_vec   : WIDTH-bit input vector
//                o_index : position of the lowest set bit (0 when none set)
//                o_any   : OR-reduction of i_vec
//  Revision    : 1.0  initial release
// ============================================================================
module lsb_priority_encoder
  import scan_defs::*;
#(
  parameter int WIDTH = SCAN_WIDTH,
  parameter int IDXW  = SCAN_IDXW
) (
  input  wire logic [WIDTH-1:0] i_vec,
  output logic      [IDXW-1:0]  o_index,
  output logic                  o_any
);

  // Walk from the top down so that the last hit written is the lowest bit.
  always_comb begin
    o_index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_index = IDXW'(i);
      end
    end
  end

  assign o_any = |i_vec;

endmodule : lsb_priority_encoder
`default_nettype wire

// File: rtl/set_bit_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : set_bit_scanner
//  Description : Expands a WIDTH-bit vector into the indices of its set bits,
//                one index per output beat, lowest bit first. An all-zero word
//                yields a single beat flagged out_empty with index 0.
//                clock : rising-edge clock
//                reset : asynchronous, active-low
//                bus   : set_bit_scanner_if.slave (in_valid/in_ready/in_data,
//                        out_valid/out_ready/out_index/out_last/out_empty)
//  Revision    : 1.0  initial release
// ============================================================================
module set_bit_scanner
  import scan_defs::*;
#(
  parameter int WIDTH = SCAN_WIDTH,
  parameter int IDXW  = SCAN_IDXW
) (
  input  wire logic         clock,
  input  wire logic         reset,
  set_bit_scanner_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  scan_state_e      state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zflag_q, zflag_d;

  logic [IDXW-1:0]  w_enc_index;
  logic             w_enc_any;
  logic [WIDTH-1:0] w_pending_drop;
  logic             w_last;

  lsb_priority_encoder #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_enc (
    .i_vec   (pending_q),
    .o_index (w_enc_index),
    .o_any   (w_enc_any)
  );

  // pending with its lowest set bit cleared; subtraction wraps in WIDTH bits,
  // so an all-zero pending stays zero after the AND.
  assign w_pending_drop = pending_q & (pending_q - c_one);

  // Final beat when the word was empty or at most one set bit remains.
  assign w_last = zflag_q || (w_pending_drop == '0);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zflag_d   = zflag_q;
    case (state_q)
      ST_IDLE: begin
        // in_data is only looked at on a handshake, so X while idle is inert.
        if (bus.in_valid) begin
          pending_d = bus.in_data;
          zflag_d   = (bus.in_data == '0);
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (bus.out_ready) begin
          if (w_last) begin
            pending_d = '0;
            zflag_d   = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            pending_d = w_pending_drop;
          end
        end
      end
      default: begin
        pending_d = '0;
        zflag_d   = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      zflag_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zflag_q   <= zflag_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: functions of registered state only. Gating with the SCAN state
  // keeps every beat output at zero while idle or while reset holds the FSM.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_index = '0;
    bus.out_last  = 1'b0;
    bus.out_empty = 1'b0;
    if (state_q == ST_SCAN) begin
      bus.out_valid = 1'b1;
      bus.out_index = w_enc_any ? w_enc_index : '0;
      bus.out_last  = w_last;
      bus.out_empty = zflag_q;
    end else begin
      bus.in_ready  = 1'b1;
    end
  end

endmodule : set_bit_scanner
`default_nettype wire
